// File: rtl/fetch_line_aligner.sv
// Maps the fetch PC onto an even/odd I$ line pair, buffers the returned 32-byte
// window and hands two aligned 32-bit instructions per handshake to decode.
module fetch_line_aligner #(
  parameter int                CL_SIZE  = 128,
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] addr_even,
  output logic [ADDR_W-1:0] addr_odd,
  input  logic              hit_even,
  input  logic              hit_odd,
  input  logic [CL_SIZE-1:0] cl_even,
  input  logic [CL_SIZE-1:0] cl_odd,
  input  logic [ADDR_W-1:0] addr_out_even,
  input  logic [ADDR_W-1:0] addr_out_odd,
  input  logic              ic_stall,
  input  logic              exception,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [31:0]       out_inst0,
  output logic [31:0]       out_inst1,
  output logic              out_fault
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_DELIVER = 2'd1,
    S_FAULT   = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LINE_BYTES = ADDR_W'(32'd16);
  localparam logic [ADDR_W-1:0] WIN_BYTES  = ADDR_W'(32'd32);

  function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] a);
    return a & ~ADDR_W'(32'd15);
  endfunction

  // The window base is always one line of the pair; the even line is the one with bit4 clear.
  function automatic logic [ADDR_W-1:0] even_of(input logic [ADDR_W-1:0] base);
    return base[4] ? base + LINE_BYTES : base;
  endfunction

  function automatic logic [ADDR_W-1:0] odd_of(input logic [ADDR_W-1:0] base);
    return base[4] ? base : base + LINE_BYTES;
  endfunction

  function automatic logic [31:0] word_at(input logic [2*CL_SIZE-1:0] win, input logic [2:0] k);
    return win[{k, 5'b00000} +: 32];
  endfunction

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d, base_q, base_d;
  logic                ev_vld_q, ev_vld_d, od_vld_q, od_vld_d, pend_q, pend_d;
  logic [CL_SIZE-1:0]  ev_line_q, ev_line_d, od_line_q, od_line_d;
  logic [ADDR_W-1:0]   addr_even_q, addr_even_d, addr_odd_q, addr_odd_d;
  logic                out_valid_q, out_valid_d, out_fault_q, out_fault_d;
  logic [ADDR_W-1:0]   out_pc_q, out_pc_d;
  logic [31:0]         out_inst0_q, out_inst0_d, out_inst1_q, out_inst1_d;
  logic [ADDR_W-1:0]   npc_s, rd_pc_s;
  logic                hs_s, rebase_s, cap_ev_s, cap_od_s;
  logic [2*CL_SIZE-1:0] win_s;
  logic [2:0]          idx_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      base_q      <= line_base(RESET_PC);
      ev_vld_q    <= 1'b0;
      od_vld_q    <= 1'b0;
      ev_line_q   <= '0;
      od_line_q   <= '0;
      pend_q      <= 1'b0;
      addr_even_q <= even_of(line_base(RESET_PC));
      addr_odd_q  <= odd_of(line_base(RESET_PC));
      out_valid_q <= 1'b0;
      out_fault_q <= 1'b0;
      out_pc_q    <= RESET_PC;
      out_inst0_q <= 32'h0000_0000;
      out_inst1_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      base_q      <= base_d;
      ev_vld_q    <= ev_vld_d;
      od_vld_q    <= od_vld_d;
      ev_line_q   <= ev_line_d;
      od_line_q   <= od_line_d;
      pend_q      <= pend_d;
      addr_even_q <= addr_even_d;
      addr_odd_q  <= addr_odd_d;
      out_valid_q <= out_valid_d;
      out_fault_q <= out_fault_d;
      out_pc_q    <= out_pc_d;
      out_inst0_q <= out_inst0_d;
      out_inst1_q <= out_inst1_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    base_d    = base_q;
    ev_vld_d  = ev_vld_q;
    od_vld_d  = od_vld_q;
    ev_line_d = ev_line_q;
    od_line_d = od_line_q;
    rebase_s  = 1'b0;
    cap_ev_s  = 1'b0;
    cap_od_s  = 1'b0;
    hs_s      = out_valid_q && out_ready;
    npc_s     = pc_q + ADDR_W'(32'd8);
    rd_pc_s   = redirect_pc & ~ADDR_W'(32'd3);

    if (redirect_valid) begin
      pc_d     = rd_pc_s;
      base_d   = line_base(rd_pc_s);
      ev_vld_d = 1'b0;
      od_vld_d = 1'b0;
      rebase_s = 1'b1;
      state_d  = S_FETCH;
    end else begin
      case (state_q)
        S_FETCH: begin
          // While the address registers lag a retarget, any hit belongs to the old request.
          cap_ev_s = !pend_q && !ev_vld_q && hit_even && (addr_out_even == addr_even_q);
          cap_od_s = !pend_q && !od_vld_q && hit_odd && (addr_out_odd == addr_odd_q);
          if (cap_ev_s) begin
            ev_line_d = cl_even;
            ev_vld_d  = 1'b1;
          end else begin
            ev_line_d = ev_line_q;
          end
          if (cap_od_s) begin
            od_line_d = cl_odd;
            od_vld_d  = 1'b1;
          end else begin
            od_line_d = od_line_q;
          end
          if (exception) begin
            state_d = S_FAULT;
          end else if (ev_vld_d && od_vld_d) begin
            state_d = S_DELIVER;
          end else begin
            state_d = S_FETCH;
          end
        end
        S_DELIVER: begin
          if (hs_s) begin
            pc_d = npc_s;
            if ((npc_s + ADDR_W'(32'd4)) < (base_q + WIN_BYTES)) begin
              state_d = S_DELIVER;
            end else if (line_base(npc_s) == (base_q + LINE_BYTES)) begin
              // Upper line of the window becomes the new base; keep it, refetch its partner.
              base_d   = base_q + LINE_BYTES;
              rebase_s = 1'b1;
              if (base_q[4]) begin
                od_vld_d = 1'b0;
              end else begin
                ev_vld_d = 1'b0;
              end
              state_d = S_FETCH;
            end else begin
              base_d   = line_base(npc_s);
              rebase_s = 1'b1;
              ev_vld_d = 1'b0;
              od_vld_d = 1'b0;
              state_d  = S_FETCH;
            end
          end else begin
            state_d = S_DELIVER;
          end
        end
        S_FAULT: begin
          state_d = S_FAULT;
        end
        default: begin
          state_d = S_FETCH;
        end
      endcase
    end

    pend_d = ic_stall && (pend_q || rebase_s);
    if (ic_stall) begin
      addr_even_d = addr_even_q;
      addr_odd_d  = addr_odd_q;
    end else begin
      addr_even_d = even_of(base_d);
      addr_odd_d  = odd_of(base_d);
    end

    win_s = base_d[4] ? {ev_line_d, od_line_d} : {od_line_d, ev_line_d};
    idx_s = 3'((pc_d - base_d) >> 2);

    out_valid_d = (state_d != S_FETCH);
    out_fault_d = (state_d == S_FAULT);
    out_pc_d    = pc_d;
    if (state_d == S_DELIVER) begin
      out_inst0_d = word_at(win_s, idx_s);
      out_inst1_d = word_at(win_s, idx_s + 3'd1);
    end else begin
      out_inst0_d = 32'h0000_0000;
      out_inst1_d = 32'h0000_0000;
    end
  end

  assign addr_even = addr_even_q;
  assign addr_odd  = addr_odd_q;
  assign out_valid = out_valid_q;
  assign out_fault = out_fault_q;
  assign out_pc    = out_pc_q;
  assign out_inst0 = out_inst0_q;
  assign out_inst1 = out_inst1_q;

endmodule

// File: tb/tb_fetch_line_aligner.sv
// Directed bench for fetch_line_aligner: an I$ data model plus an expected-pair
// scoreboard, checked with immediate assertions.
module tb_fetch_line_aligner;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  addr_even, addr_odd, addr_out_even = 32'h0, addr_out_odd = 32'h0;
  logic         hit_even = 1'b0, hit_odd = 1'b0;
  logic [127:0] cl_even = '0, cl_odd = '0;
  logic         ic_stall = 1'b0, exception = 1'b0, redirect_valid = 1'b0, out_ready = 1'b0;
  logic [31:0]  redirect_pc = 32'h0;
  logic         out_valid, out_fault;
  logic [31:0]  out_pc, out_inst0, out_inst1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] i0;
    logic [31:0] i1;
    logic        fault;
  } exp_t;
  exp_t sb_q[$];

  fetch_line_aligner dut (
    .clk(clk), .rst(rst),
    .addr_even(addr_even), .addr_odd(addr_odd),
    .hit_even(hit_even), .hit_odd(hit_odd),
    .cl_even(cl_even), .cl_odd(cl_odd),
    .addr_out_even(addr_out_even), .addr_out_odd(addr_out_odd),
    .ic_stall(ic_stall), .exception(exception),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst0(out_inst0), .out_inst1(out_inst1),
    .out_fault(out_fault)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Instruction memory model: every byte address has a distinct word.
  function automatic logic [31:0] mw(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  function automatic logic [127:0] mline(input logic [31:0] la);
    return {mw(la + 32'd12), mw(la + 32'd8), mw(la + 32'd4), mw(la)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic fault);
    exp_t e;
    e.pc    = pc;
    e.fault = fault;
    e.i0    = fault ? 32'h0 : mw(pc);
    e.i1    = fault ? 32'h0 : mw(pc + 32'd4);
    sb_q.push_back(e);
  endtask

  task automatic pop_cmp(input string tag);
    exp_t e;
    chk({tag, ".valid"}, {63'h0, out_valid}, 64'h1);
    chk({tag, ".sb_nonempty"}, {32'h0, sb_q.size()}, (sb_q.size() > 0) ? {32'h0, sb_q.size()} : 64'h1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({tag, ".pc"}, {32'h0, out_pc}, {32'h0, e.pc});
      chk({tag, ".inst0"}, {32'h0, out_inst0}, {32'h0, e.i0});
      chk({tag, ".inst1"}, {32'h0, out_inst1}, {32'h0, e.i1});
      chk({tag, ".fault"}, {63'h0, out_fault}, {63'h0, e.fault});
    end
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) chk({tag, ".timeout"}, {63'h0, out_valid}, 64'h1);
  endtask

  task automatic drive_hits(input logic he, input logic [31:0] ae, input logic ho, input logic [31:0] ao);
    hit_even = he; addr_out_even = ae; cl_even = mline(ae);
    hit_odd  = ho; addr_out_odd  = ao; cl_odd  = mline(ao);
    step();
    hit_even = 1'b0;
    hit_odd  = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    step();
    redirect_valid = 1'b0;
  endtask

  task automatic chk_addr(input string tag, input logic [31:0] ev, input logic [31:0] od);
    chk({tag, ".addr_even"}, {32'h0, addr_even}, {32'h0, ev});
    chk({tag, ".addr_odd"}, {32'h0, addr_odd}, {32'h0, od});
  endtask

  initial begin
    // Reset state
    step();
    step();
    chk_addr("reset", 32'h0, 32'h10);
    chk("reset.valid", {63'h0, out_valid}, 64'h0);
    chk("reset.fault", {63'h0, out_fault}, 64'h0);
    chk("reset.pc", {32'h0, out_pc}, 64'h0);
    chk("reset.inst0", {32'h0, out_inst0}, 64'h0);
    chk("reset.inst1", {32'h0, out_inst1}, 64'h0);
    rst = 1'b0;
    step();

    // Even then odd, three cycles apart, with a mismatched odd hit in between
    drive_hits(1'b1, 32'h0, 1'b0, 32'h0);
    chk("one_line.valid", {63'h0, out_valid}, 64'h0);
    drive_hits(1'b0, 32'h0, 1'b1, 32'h30);
    step();
    chk("bad_addr.valid", {63'h0, out_valid}, 64'h0);
    push_exp(32'h0, 1'b0);
    drive_hits(1'b0, 32'h0, 1'b1, 32'h10);
    pop_cmp("first_pair");

    // Cross-line pair: odd word3 + even word0
    redirect(32'h1C);
    chk("redir1c.valid", {63'h0, out_valid}, 64'h0);
    chk_addr("redir1c", 32'h20, 32'h10);
    push_exp(32'h1C, 1'b0);
    drive_hits(1'b1, 32'h20, 1'b1, 32'h10);
    pop_cmp("cross_pair");

    // Redirect coinciding with a handshake discards the pc increment
    out_ready = 1'b1;
    redirect(32'h4);
    chk("redir_hs.valid", {63'h0, out_valid}, 64'h0);
    chk_addr("redir_hs", 32'h0, 32'h10);

    // Sequential stream inside the window, then partial line reuse
    push_exp(32'h4, 1'b0);
    push_exp(32'hC, 1'b0);
    push_exp(32'h14, 1'b0);
    drive_hits(1'b1, 32'h0, 1'b1, 32'h10);
    pop_cmp("seq04");
    step();
    pop_cmp("seq0c");
    chk_addr("seq0c", 32'h0, 32'h10);
    step();
    pop_cmp("seq14");
    chk_addr("seq14", 32'h0, 32'h10);
    step();
    chk("reuse.valid", {63'h0, out_valid}, 64'h0);
    chk_addr("reuse", 32'h20, 32'h10);
    out_ready = 1'b0;
    push_exp(32'h1C, 1'b0);
    drive_hits(1'b1, 32'h20, 1'b0, 32'h0);
    wait_valid("reuse");
    pop_cmp("reuse1c");

    // Backpressure keeps outputs stable
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold.pc", {32'h0, out_pc}, 64'h1C);
      chk("hold.inst0", {32'h0, out_inst0}, {32'h0, mw(32'h1C)});
      chk("hold.inst1", {32'h0, out_inst1}, {32'h0, mw(32'h20)});
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    push_exp(32'h24, 1'b0);
    pop_cmp("after_hold");

    // Redirect under ic_stall: addresses frozen, stale hits ignored
    ic_stall = 1'b1;
    redirect(32'h103);
    chk("stall.valid", {63'h0, out_valid}, 64'h0);
    chk_addr("stall", 32'h20, 32'h10);
    drive_hits(1'b1, 32'h20, 1'b1, 32'h10);
    step();
    chk("stale.valid", {63'h0, out_valid}, 64'h0);
    chk_addr("stale", 32'h20, 32'h10);
    ic_stall = 1'b0;
    step();
    chk_addr("unstall", 32'h100, 32'h110);
    chk("unstall.valid", {63'h0, out_valid}, 64'h0);
    push_exp(32'h100, 1'b0);
    drive_hits(1'b1, 32'h100, 1'b1, 32'h110);
    pop_cmp("pair100");

    // Fetch exception: sticky fault marker until redirect
    redirect(32'h40);
    chk_addr("redir40", 32'h40, 32'h50);
    exception = 1'b1;
    step();
    exception = 1'b0;
    push_exp(32'h40, 1'b1);
    pop_cmp("fault0");
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      push_exp(32'h40, 1'b1);
      pop_cmp("fault_hs");
    end
    out_ready = 1'b0;
    redirect(32'h200);
    chk("fault_clr.valid", {63'h0, out_valid}, 64'h0);
    chk("fault_clr.fault", {63'h0, out_fault}, 64'h0);
    chk_addr("redir200", 32'h200, 32'h210);

    // Asynchronous reset in the middle of a fetch
    drive_hits(1'b1, 32'h200, 1'b0, 32'h0);
    rst = 1'b1;
    #1;
    chk_addr("midrst", 32'h0, 32'h10);
    chk("midrst.valid", {63'h0, out_valid}, 64'h0);
    chk("midrst.pc", {32'h0, out_pc}, 64'h0);
    #2;
    rst = 1'b0;
    step();
    drive_hits(1'b0, 32'h0, 1'b1, 32'h10);
    chk("postrst.valid", {63'h0, out_valid}, 64'h0);
    push_exp(32'h0, 1'b0);
    drive_hits(1'b1, 32'h0, 1'b0, 32'h0);
    pop_cmp("postrst_pair");

    chk("sb_empty", {32'h0, sb_q.size()}, 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_line_aligner.md
Name: fetch_line_aligner

Overview:
- Front-end fetch stage directly upstream and downstream of the memory system's I$ port.
- Generates the even/odd line address pair for the current fetch PC and captures the returned 128-bit even and odd lines into a 32-byte window buffer.
- Delivers two aligned 32-bit instructions per handshake to decode.
- Handles cross-line fetch, partial line reuse, redirects, I$ stall and fetch exceptions.

Parameters:
- CL_SIZE, 128, cache line width in bits (16 bytes); block supports only 128.
- ADDR_W, 32, address width.
- RESET_PC, 32'h0000_0000, fetch PC after reset.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- addr_even  out  ADDR_W  even-line request address to I$ (bit4=0, bits[3:0]=0)
- addr_odd  out  ADDR_W  odd-line request address to I$ (bit4=1, bits[3:0]=0)
- hit_even  in  1  I$ even line valid this cycle
- hit_odd  in  1  I$ odd line valid this cycle
- cl_even  in  CL_SIZE  even line data
- cl_odd  in  CL_SIZE  odd line data
- addr_out_even  in  ADDR_W  address of returned even line
- addr_out_odd  in  ADDR_W  address of returned odd line
- ic_stall  in  1  I$ busy; request addresses must not change
- exception  in  1  I$ fetch fault for current request
- redirect_valid  in  1  resteer from branch unit/ROB
- redirect_pc  in  ADDR_W  resteer target; bits[1:0] ignored (forced 0)
- out_valid  out  1  instruction pair valid to decode
- out_ready  in  1  decode accepts pair
- out_pc  out  ADDR_W  PC of out_inst0
- out_inst0  out  32  instruction at out_pc
- out_inst1  out  32  instruction at out_pc+4
- out_fault  out  1  pair is a fetch fault marker, instructions invalid

Behaviour:
- Pair mapping from pc:
  - pc[4]=0: addr_even={pc[31:5],5'b0}, addr_odd=addr_even+16.
  - pc[4]=1: addr_odd={pc[31:4],4'b0}, addr_even=addr_odd+16.
  - Window base = {pc[31:4],4'b0}; the window covers base..base+31.
- States: FETCH, DELIVER, FAULT.
- Reset: state=FETCH, pc=RESET_PC, both line-valid flags=0, pending redirect=0, addr_even/addr_odd per mapping (0x0/0x10 at default), out_valid=0, out_fault=0, out_pc=RESET_PC, out_inst0/1=0.
- FETCH:
  - Addresses are held constant.
  - Even line is captured on the first cycle with hit_even && addr_out_even==addr_even; odd line is captured likewise. The two may arrive in any order or in the same cycle.
  - Hits with a mismatched addr_out are ignored.
  - When both flags are set (including a capture this cycle), go to DELIVER next cycle. Minimum latency from both hits to out_valid is 1 cycle.
  - exception=1 goes to FAULT.
- DELIVER:
  - out_valid=1. out_inst0 = window word at (pc-base)>>2; out_inst1 = next word. Word k in 0..3 is from the base line, k in 4..7 is from base+16. Byte little-endian: word0=cl[31:0].
  - Outputs remain stable while out_ready=0.
  - On handshake, npc=pc+8:
    - If npc+4 < base+32, stay in DELIVER with no request.
    - Else if npc's line is buffered, keep that line's flag and clear the other. The new mapping must reproduce the kept line's address. Go to FETCH.
    - Else clear both flags and go to FETCH.
- FAULT: out_valid=1, out_fault=1, out_pc=pc, inst=0. Handshakes are accepted, but the block stays in FAULT until a redirect.
- Redirect:
  - Highest priority in any state. It overrides a same-cycle handshake: the pair is consumed by decode, but the pc increment is discarded.
  - Effect: pc=redirect_pc&~3, clear both flags, out_valid=0 next cycle, go to FETCH.
  - If ic_stall=1 that cycle, latch the target as pending. Addresses update on the first cycle with ic_stall=0; captures are blocked while a redirect is pending.
- ic_stall never blocks captures; it only freezes address changes. Address changes from handshakes are also deferred while ic_stall=1.
- is_write outputs of the I$ are not consumed.

Test Plan:
- Reset at RESET_PC=0; even line words {A0..A3} at 0x0 and odd {B0..B3} at 0x10 hit 3 cycles apart -> addr_even=0x0, addr_odd=0x10; out_valid one cycle after the second hit with out_pc=0, inst0=A0, inst1=A1.
- Redirect to 0x1C -> addr_odd=0x10, addr_even=0x20; out_inst0=odd word3, out_inst1=even word0.
- Sequential from 0x4 with out_ready=1:
  - Pairs at 0x4, 0xC and 0x14 are delivered with no new request.
  - At npc=0x1C the odd line 0x10 is kept, only even 0x20 is awaited, and the odd hit is not needed.
- out_ready=0 for 5 cycles in DELIVER -> out_pc/inst unchanged; redirect_valid with out_ready=1 in the same cycle -> pc=redirect target, not pc+8.
- ic_stall=1 while a redirect to 0x100 arrives -> addr_even/odd unchanged until ic_stall drops, then 0x100/0x110; a stale hit with addr_out=old address is ignored.
- exception during FETCH at pc=0x40 -> out_valid=1, out_fault=1, out_pc=0x40; it persists across handshakes and clears on redirect. Asserting rst mid-FETCH clears out_valid and returns addresses to 0x0/0x10 immediately.
